tinytpu_ctrl: RTL

Sequencer for the tinytpu systolic datapath (D_W-bit operands, N x N array, WORD = N*N elements per matrix). It deserialises the X and Y matrices from the bit-serial input pins into the operand buffer, then runs the array for the fixed compute window. It then streams the Z result matrix out MSB-first on the serial output with a tx_ready qualifier. It sits between the top-level pin wrapper and the buffer/array datapath and owns all phase control.

---
 rtl/tinytpu_ctrl_if.sv | 29 ++
 rtl/tinytpu_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tinytpu_ctrl_if.sv
// Bus between the tinytpu sequencer (master) and the operand buffer / systolic array datapath (slave).
interface tinytpu_ctrl_if #(
    parameter int D_W  = 8,
    parameter int N    = 2,
    parameter int WORD = 4,
    parameter int Z_W  = 17,
    parameter int AW   = (WORD > 1) ? $clog2(WORD) : 1,
    parameter int SW   = $clog2(3*N-2) + 1
);
    logic           buf_we;
    logic [AW-1:0]  buf_addr;
    logic [D_W-1:0] buf_x;
    logic [D_W-1:0] buf_y;
    logic           arr_clr;
    logic           arr_en;
    logic [SW-1:0]  arr_step;
    logic [AW-1:0]  z_sel;
    logic [Z_W-1:0] z_data;

    modport master (
        output buf_we, buf_addr, buf_x, buf_y, arr_clr, arr_en, arr_step, z_sel,
        input  z_data
    );

    modport slave (
        input  buf_we, buf_addr, buf_x, buf_y, arr_clr, arr_en, arr_step, z_sel,
        output z_data
    );
endinterface

// File: rtl/tinytpu_ctrl.sv
// tinytpu phase sequencer: serial operand load, buffer commit, fixed compute window, serial result TX.
module tinytpu_ctrl #(
    parameter int D_W  = 8,
    parameter int N    = 2,
    parameter int WORD = 4,
    parameter int Z_W  = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init_i,
    input  logic           load_en_i,
    input  logic           data_in_x_i,
    input  logic           data_in_y_i,
    output logic           data_out_z_o,
    output logic           tx_ready_o,
    output logic           busy_o,
    output logic           done_o,
    tinytpu_ctrl_if.master bus
);
    localparam int AW        = (WORD > 1) ? $clog2(WORD) : 1;
    localparam int SW        = $clog2(3*N-2) + 1;
    localparam int BW        = (D_W > 1) ? $clog2(D_W) : 1;
    localparam int TW        = (Z_W > 1) ? $clog2(Z_W) : 1;
    localparam int LAST_STEP = 3*N - 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMMIT, S_COMPUTE, S_TX} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  bc_q, bc_d;
    logic [AW-1:0]  ec_q, ec_d;
    logic [SW-1:0]  step_q, step_d;
    logic [TW-1:0]  tb_q, tb_d;
    logic [AW-1:0]  zi_q, zi_d;
    // Only D_W-1 bits are kept; the final bit is taken straight from the pin when the element completes.
    logic [D_W-2:0] x_sr_q, x_sr_d, y_sr_q, y_sr_d;
    logic [D_W-1:0] x_full, y_full;
    logic           elem_done, tx_last;

    logic           buf_we_q, buf_we_d;
    logic [AW-1:0]  buf_addr_q, buf_addr_d;
    logic [D_W-1:0] buf_x_q, buf_x_d, buf_y_q, buf_y_d;
    logic           arr_clr_q, arr_clr_d;
    logic           arr_en_q, arr_en_d;
    logic           tx_ready_q, tx_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    assign x_full = {x_sr_q, data_in_x_i};
    assign y_full = {y_sr_q, data_in_y_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bc_q       <= '0;
            ec_q       <= '0;
            step_q     <= '0;
            tb_q       <= '0;
            zi_q       <= '0;
            x_sr_q     <= '0;
            y_sr_q     <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_x_q    <= '0;
            buf_y_q    <= '0;
            arr_clr_q  <= 1'b0;
            arr_en_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            ec_q       <= ec_d;
            step_q     <= step_d;
            tb_q       <= tb_d;
            zi_q       <= zi_d;
            x_sr_q     <= x_sr_d;
            y_sr_q     <= y_sr_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_x_q    <= buf_x_d;
            buf_y_q    <= buf_y_d;
            arr_clr_q  <= arr_clr_d;
            arr_en_q   <= arr_en_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Step and TX counters default to zero so they are always clean on entry to their phase.
    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        ec_d      = ec_q;
        step_d    = '0;
        tb_d      = '0;
        zi_d      = '0;
        x_sr_d    = x_sr_q;
        y_sr_d    = y_sr_q;
        elem_done = 1'b0;
        tx_last   = 1'b0;
        if (init_i) begin
            state_d = S_LOAD;
            bc_d    = '0;
            ec_d    = '0;
            x_sr_d  = '0;
            y_sr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    if (load_en_i) begin
                        x_sr_d = x_full[D_W-2:0];
                        y_sr_d = y_full[D_W-2:0];
                        if (bc_q == BW'(D_W-1)) begin
                            bc_d      = '0;
                            elem_done = 1'b1;
                            if (ec_q == AW'(WORD-1)) begin
                                ec_d    = '0;
                                state_d = S_COMMIT;
                            end else begin
                                ec_d = ec_q + 1'b1;
                            end
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: state_d = S_COMPUTE;
                S_COMPUTE: begin
                    if (step_q == SW'(LAST_STEP)) begin
                        state_d = S_TX;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_TX: begin
                    tb_d = tb_q + 1'b1;
                    zi_d = zi_q;
                    if (tb_q == TW'(Z_W-1)) begin
                        tb_d = '0;
                        if (zi_q == AW'(WORD-1)) begin
                            zi_d    = '0;
                            tx_last = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            zi_d = zi_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        arr_clr_d  = init_i;
        arr_en_d   = (state_d == S_COMPUTE);
        tx_ready_d = (state_d == S_TX);
        busy_d     = (state_d != S_IDLE);
        done_d     = tx_last;
        buf_we_d   = elem_done;
        buf_addr_d = elem_done ? ec_q   : buf_addr_q;
        buf_x_d    = elem_done ? x_full : buf_x_q;
        buf_y_d    = elem_done ? y_full : buf_y_q;
    end

    assign bus.buf_we   = buf_we_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_x    = buf_x_q;
    assign bus.buf_y    = buf_y_q;
    assign bus.arr_clr  = arr_clr_q;
    assign bus.arr_en   = arr_en_q;
    assign bus.arr_step = step_q;
    assign bus.z_sel    = zi_q;

    assign data_out_z_o = tx_ready_q & bus.z_data[TW'(Z_W-1) - tb_q];
    assign tx_ready_o   = tx_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule
